// File: rtl/norm_shift_seq_if.sv
// norm_shift_seq_if
//   Request/result bundle for the sequential mantissa normalizer.
//   master : drives start/din and observes the result (datapath control side)
//   slave  : the normalizer itself
//   Signals: start, din (request); busy, done, dout, shamt, rightleft, zero,
//   sticky (status/result).
interface norm_shift_seq_if #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic [SW-1:0]    shamt;
  logic             rightleft;
  logic             zero;
  logic             sticky;

  modport master (
    output start, din,
    input  busy, done, dout, shamt, rightleft, zero, sticky
  );

  modport slave (
    input  start, din,
    output busy, done, dout, shamt, rightleft, zero, sticky
  );
endinterface

// File: rtl/norm_shift_seq.sv
// norm_shift_seq
//   Sequential mantissa normalizer: shifts an unnormalized WIDTH-bit magnitude
//   one bit per clock until its leading one sits at bit TARGET, and reports
//   the shift count and direction so exponent logic can compensate.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    norm_shift_seq_if.slave (start/din in; busy/done/dout/shamt/
//            rightleft/zero/sticky out)
//
//   Build option: define NORM_SHIFT_STICKY_EN to accumulate the OR of all bits
//   lost on right shifts into sticky; otherwise sticky is tied to 0.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold last result
//   SHIFT | one 1-bit shift per clock until aligned (or input was zero)
//   DONE  | result valid, done pulses for one cycle
module norm_shift_seq #(
  parameter int WIDTH  = 32,
  parameter int TARGET = 23,
  parameter int SW     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  norm_shift_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  // Bits TARGET..WIDTH-1: all-zero at load means the value must move left.
  localparam logic [WIDTH-1:0] LOAD_MASK = ~(ONES >> (WIDTH - TARGET));
  // Bits TARGET+1..WIDTH-1: must be clear once aligned. Mask form avoids an
  // empty slice when TARGET == WIDTH-1.
  localparam logic [WIDTH-1:0] HI_MASK = ~(ONES >> (WIDTH - 1 - TARGET));

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_shamt;
  logic             r_rightleft;
  logic             r_zero;

  logic w_aligned;
  logic w_is_zero;

  assign w_is_zero = (r_data == '0);
  assign w_aligned = r_data[TARGET] && ((r_data & HI_MASK) == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_shamt     <= '0;
      r_rightleft <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_data      <= bus.din;
            r_shamt     <= '0;
            r_zero      <= 1'b0;
            r_rightleft <= ((bus.din & LOAD_MASK) == '0);
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_is_zero) begin
            r_zero  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_aligned) begin
            r_state <= S_DONE;
          end else begin
            r_data  <= r_rightleft ? (r_data << 1) : (r_data >> 1);
            r_shamt <= r_shamt + SW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef NORM_SHIFT_STICKY_EN
  logic r_sticky;

  // Mirrors the shift decision above: only a real right shift loses r_data[0].
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (bus.start) r_sticky <= 1'b0;
    end else if (r_state == S_SHIFT && !w_is_zero && !w_aligned && !r_rightleft) begin
      r_sticky <= r_sticky | r_data[0];
    end
  end

  assign bus.sticky = r_sticky;
`else
  assign bus.sticky = 1'b0;
`endif

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.dout      = r_data;
  assign bus.shamt     = r_shamt;
  assign bus.rightleft = r_rightleft;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_norm_shift_seq.sv
module tb_norm_shift_seq;

  localparam int WIDTH  = 32;
  localparam int TARGET = 23;
  localparam int SW     = $clog2(WIDTH);

`ifdef NORM_SHIFT_STICKY_EN
  localparam logic STICKY_ON = 1'b1;
`else
  localparam logic STICKY_ON = 1'b0;
`endif

  typedef struct {
    string            name;
    logic [WIDTH-1:0] dout;
    logic [SW-1:0]    shamt;
    logic             rl;
    logic             zero;
    logic             sticky;
    int               cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   n_done;
  exp_t sb[$];

  norm_shift_seq_if #(.WIDTH(WIDTH), .SW(SW)) bus ();

  norm_shift_seq #(.WIDTH(WIDTH), .TARGET(TARGET), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, ".latency"},   cyc,          e.cyc);
        chk({e.name, ".dout"},      bus.dout,     e.dout);
        chk({e.name, ".shamt"},     bus.shamt,    e.shamt);
        chk({e.name, ".rightleft"}, bus.rightleft, e.rl);
        chk({e.name, ".zero"},      bus.zero,     e.zero);
        chk({e.name, ".sticky"},    bus.sticky,   e.sticky);
      end
    end
  end

  task automatic issue(input string name, input logic [WIDTH-1:0] d, input int k,
                       input logic [WIDTH-1:0] edout, input logic erl,
                       input logic ezero, input logic esticky);
    exp_t e;
    @(negedge clk);
    bus.din   = d;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e.name   = name;
    e.dout   = edout;
    e.shamt  = SW'(k);
    e.rl     = erl;
    e.zero   = ezero;
    e.sticky = esticky;
    e.cyc    = cyc + k + 1;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || sb.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk({name, ".timeout"}, 1, 0);
      sb.delete();
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    n_done    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.din   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.busy",  bus.busy, 0);
    chk("reset.done",  bus.done, 0);
    chk("reset.dout",  bus.dout, 0);
    chk("reset.shamt", bus.shamt, 0);
    rst_n = 1'b1;

    // 1: already aligned
    issue("t1", 32'h0080_0000, 0, 32'h0080_0000, 1'b0, 1'b0, 1'b0);
    wait_idle("t1");

    // 2: left by 21
    issue("t2", 32'h0000_0005, 21, 32'h00A0_0000, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2.busy_mid", bus.busy, 1);
    wait_idle("t2");

    // 3: right by 8, ones lost
    issue("t3", 32'hAAAA_AAAA, 8, 32'h00AA_AAAA, 1'b0, 1'b0, STICKY_ON);
    wait_idle("t3");

    // 4: zero, then a single right shift
    issue("t4a", 32'h0000_0000, 0, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    wait_idle("t4a");
    issue("t4b", 32'h0100_0000, 1, 32'h0080_0000, 1'b0, 1'b0, 1'b0);
    wait_idle("t4b");

    // 5: reset mid-shift after 5 shifts, then rerun
    @(negedge clk);
    bus.din   = 32'h0000_0001;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t5.pre_reset_shamt", bus.shamt, 5);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5.rst_busy",  bus.busy, 0);
    chk("t5.rst_dout",  bus.dout, 0);
    chk("t5.rst_shamt", bus.shamt, 0);
    chk("t5.rst_rl",    bus.rightleft, 0);
    chk("t5.rst_zero",  bus.zero, 0);
    chk("t5.rst_done",  bus.done, 0);
    chk("t5.rst_stky",  bus.sticky, 0);
    issue("t5", 32'h0000_0001, 23, 32'h0080_0000, 1'b1, 1'b0, 1'b0);
    wait_idle("t5");

    // 6: start pulses during SHIFT and DONE are ignored
    n_done = 0;
    issue("t6", 32'h8000_0000, 8, 32'h0080_0000, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    bus.din   = 32'h0000_0001;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus.done && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("t6.reach_done", bus.done, 1);
    end
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6.busy_after", bus.busy, 0);
    chk("t6.done_count", n_done, 1);
    chk("t6.dout_hold",  bus.dout, 32'h0080_0000);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
